// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_sequencer_pkg;

    localparam int ADDR_W = 32;
    localparam int IMM_W  = 16;
    localparam int JIDX_W = 26;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE    = 2'b00;
    localparam state_t S_FETCH   = 2'b01;
    localparam state_t S_RESOLVE = 2'b10;

    // Word offset -> byte offset: sign-extend and scale by 4.
    function automatic logic [ADDR_W-1:0] branch_offset(input logic [IMM_W-1:0] imm);
        return {{(ADDR_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_target_adder.sv
// Branch target adder: o_sum = i_base + i_offset, modulo 2^32.
// Latency: combinational.
// Backpressure: none.
// Ports: i_base (PC+4), i_offset (byte offset, already scaled), o_sum (target).
module pc_target_adder
    import pc_sequencer_pkg::*;
(
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_offset,
    output logic [ADDR_W-1:0] o_sum
);

    assign o_sum = i_base + i_offset;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: fetch at PC, wait for resolve, load next PC.
// Latency: IDLE 1 cycle, FETCH until IMemAck, RESOLVE until ResolveValid & !Stall.
// Backpressure: IMemAck stretches FETCH indefinitely; Stall holds RESOLVE.
// Ports: Clk/Rst (async active-high); IMemReq/IMemAddr/IMemAck fetch handshake;
//        InstrValid decode pulse; ResolveValid/Branch/Zero/Jump/Imm/JumpIndex/Stall
//        resolve inputs; PC/PCPlus4/InstrCount status outputs.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic              IMemReq,
    output logic [ADDR_W-1:0] IMemAddr,
    input  logic              IMemAck,
    output logic              InstrValid,
    input  logic              ResolveValid,
    input  logic              Branch,
    input  logic              Zero,
    input  logic              Jump,
    input  logic [IMM_W-1:0]  Imm,
    input  logic [JIDX_W-1:0] JumpIndex,
    input  logic              Stall,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PCPlus4,
    output logic [ADDR_W-1:0] InstrCount
);

    // Word alignment is enforced at reset; every later PC source is aligned by construction.
    localparam logic [ADDR_W-1:0] RESET_PC_AL = {RESET_PC[ADDR_W-1:2], 2'b00};

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_count;
    logic              r_instr_valid;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_branch_target;
    logic [ADDR_W-1:0] w_jump_target;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_fetch_done;
    logic              w_retire;

    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_jump_target = {w_pc_plus4[ADDR_W-1:28], JumpIndex, 2'b00};

    pc_target_adder u_target_adder (
        .i_base   (w_pc_plus4),
        .i_offset (branch_offset(Imm)),
        .o_sum    (w_branch_target)
    );

    // Jump outranks a taken branch.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (Jump) begin
            w_next_pc = w_jump_target;
        end else if (Branch && Zero) begin
            w_next_pc = w_branch_target;
        end
    end

    // Handshake qualifiers: inputs only count in their own state.
    assign w_fetch_done = (r_state == S_FETCH) && IMemAck;
    assign w_retire     = (r_state == S_RESOLVE) && ResolveValid && !Stall;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC_AL;
            r_count       <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            // High only in the first RESOLVE cycle, since FETCH is left on the same edge.
            r_instr_valid <= w_fetch_done;
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (w_fetch_done) begin
                        r_state <= S_RESOLVE;
                    end
                end
                S_RESOLVE: begin
                    if (w_retire) begin
                        r_state <= S_FETCH;
                        r_pc    <= w_next_pc;
                        r_count <= r_count + 32'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Request decoded straight from state so reset drops it without waiting for an edge.
    assign IMemReq    = (r_state == S_FETCH);
    assign IMemAddr   = r_pc;
    assign InstrValid = r_instr_valid;
    assign PC         = r_pc;
    assign PCPlus4    = w_pc_plus4;
    assign InstrCount = r_count;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        IMemAck;
    logic        ResolveValid;
    logic        Branch;
    logic        Zero;
    logic        Jump;
    logic [15:0] Imm;
    logic [25:0] JumpIndex;
    logic        Stall;

    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] InstrCount;

    logic        d2_req;
    logic [31:0] d2_addr;
    logic        d2_ivld;
    logic [31:0] d2_pc;
    logic [31:0] d2_pc4;
    logic [31:0] d2_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: architectural PC and retired-instruction count.
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    always #5 Clk = ~Clk;

    pc_sequencer #(.RESET_PC(32'h0000_0040)) u_dut (
        .Clk(Clk), .Rst(Rst), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck),
        .InstrValid(InstrValid), .ResolveValid(ResolveValid), .Branch(Branch), .Zero(Zero),
        .Jump(Jump), .Imm(Imm), .JumpIndex(JumpIndex), .Stall(Stall),
        .PC(PC), .PCPlus4(PCPlus4), .InstrCount(InstrCount)
    );

    // Second instance with a misaligned reset PC.
    pc_sequencer #(.RESET_PC(32'h0000_0043)) u_dut2 (
        .Clk(Clk), .Rst(Rst), .IMemReq(d2_req), .IMemAddr(d2_addr), .IMemAck(IMemAck),
        .InstrValid(d2_ivld), .ResolveValid(ResolveValid), .Branch(Branch), .Zero(Zero),
        .Jump(Jump), .Imm(Imm), .JumpIndex(JumpIndex), .Stall(Stall),
        .PC(d2_pc), .PCPlus4(d2_pc4), .InstrCount(d2_cnt)
    );

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic br,
                                               input logic z, input logic jp,
                                               input logic [15:0] imm, input logic [25:0] idx);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        if (jp) return (p4 & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
        if (br && z) return p4 + 32'(int'($signed(imm)) * 4);
        return p4;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Rst   = 1'b1;
        m_pc  = 32'h0000_0040;
        m_cnt = 32'd0;
        #2;
        chk("rst_pc", PC, m_pc);
        chk("rst_cnt", InstrCount, 32'd0);
        chkb("rst_req", IMemReq, 1'b0);
        chkb("rst_ivld", InstrValid, 1'b0);
        tick();
        Rst = 1'b0;
        chkb("idle_req", IMemReq, 1'b0);
        tick();
    endtask

    // Expects the DUT in FETCH; leaves it in the first RESOLVE cycle.
    task automatic do_fetch(input int delay);
        chkb("fetch_req", IMemReq, 1'b1);
        chk("fetch_addr", IMemAddr, m_pc);
        for (int i = 0; i < delay; i++) begin
            IMemAck      = 1'b0;
            ResolveValid = 1'($urandom_range(0, 1));
            Jump         = 1'($urandom_range(0, 1));
            Branch       = 1'($urandom_range(0, 1));
            Zero         = 1'($urandom_range(0, 1));
            Stall        = 1'($urandom_range(0, 1));
            tick();
            chkb("wait_req", IMemReq, 1'b1);
            chk("wait_addr", IMemAddr, m_pc);
            chkb("wait_ivld", InstrValid, 1'b0);
        end
        IMemAck = 1'b1;
        tick();
        IMemAck      = 1'b0;
        ResolveValid = 1'b0;
        Stall        = 1'b0;
        chkb("ivld_pulse", InstrValid, 1'b1);
        chkb("resolve_req", IMemReq, 1'b0);
        chk("resolve_pc", PC, m_pc);
    endtask

    // Expects the DUT in RESOLVE; leaves it in FETCH with the next PC.
    task automatic do_resolve(input logic br, input logic z, input logic jp,
                              input logic [15:0] imm, input logic [25:0] idx,
                              input int idle, input int stalls);
        Branch    = br;
        Zero      = z;
        Jump      = jp;
        Imm       = imm;
        JumpIndex = idx;
        for (int i = 0; i < idle; i++) begin
            ResolveValid = 1'b0;
            Stall        = 1'b0;
            IMemAck      = 1'b1;
            tick();
            chk("idle_pc", PC, m_pc);
            chk("idle_cnt", InstrCount, m_cnt);
            chkb("idle_req", IMemReq, 1'b0);
            chkb("idle_ivld", InstrValid, 1'b0);
        end
        IMemAck = 1'b0;
        for (int i = 0; i < stalls; i++) begin
            ResolveValid = 1'b1;
            Stall        = 1'b1;
            tick();
            chk("stall_pc", PC, m_pc);
            chk("stall_cnt", InstrCount, m_cnt);
            chkb("stall_req", IMemReq, 1'b0);
            chkb("stall_ivld", InstrValid, 1'b0);
        end
        ResolveValid = 1'b1;
        Stall        = 1'b0;
        tick();
        ResolveValid = 1'b0;
        m_pc  = model_next(m_pc, br, z, jp, imm, idx);
        m_cnt = m_cnt + 32'd1;
        chk("retire_pc", PC, m_pc);
        chk("retire_cnt", InstrCount, m_cnt);
        chk("retire_pc4", PCPlus4, m_pc + 32'd4);
        chkb("retire_req", IMemReq, 1'b1);
    endtask

    initial begin
        IMemAck      = 1'b0;
        ResolveValid = 1'b0;
        Branch       = 1'b0;
        Zero         = 1'b0;
        Jump         = 1'b0;
        Imm          = 16'd0;
        JumpIndex    = 26'd0;
        Stall        = 1'b0;
        #3;
        Rst = 1'b1;
        #1;
        chk("misalign_rst_pc", d2_pc, 32'h0000_0040);
        do_reset();

        // Sequential fetch from the reset PC.
        do_fetch(0);
        do_resolve(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 0, 0);
        chk("seq_pc1", PC, 32'h0000_0044);
        do_fetch(0);
        do_resolve(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 0, 0);
        chk("seq_cnt2", InstrCount, 32'd2);
        chk("seq_pc2", PC, 32'h0000_0048);

        // Backward branch across zero, then silent wrap of PC+4.
        do_fetch(1);
        do_resolve(1'b1, 1'b1, 1'b0, 16'hFFEC, 26'h0, 0, 0);
        chk("br_to_top", PC, 32'hFFFF_FFFC);
        do_fetch(2);
        do_resolve(1'b0, 1'b1, 1'b0, 16'h7FFF, 26'h0, 2, 0);
        chk("wrap_pc", PC, 32'h0000_0000);

        // Branch taken / not taken from 0x100.
        do_fetch(0);
        do_resolve(1'b0, 1'b0, 1'b1, 16'h0, 26'h0000040, 0, 0);
        chk("jmp_100", PC, 32'h0000_0100);
        do_fetch(0);
        do_resolve(1'b1, 1'b1, 1'b0, 16'hFFFE, 26'h0, 0, 0);
        chk("br_taken", PC, 32'h0000_00FC);
        do_fetch(0);
        do_resolve(1'b0, 1'b0, 1'b1, 16'h0, 26'h0000040, 0, 0);
        do_fetch(0);
        do_resolve(1'b1, 1'b0, 1'b0, 16'hFFFE, 26'h0, 0, 3);
        chk("br_not_taken", PC, 32'h0000_0104);

        // Climb to 0x1000_0008, then jump beating a taken branch.
        do_fetch(0);
        do_resolve(1'b0, 1'b0, 1'b1, 16'h0, 26'h3FFFFFC, 0, 0);
        chk("jmp_hi", PC, 32'h0FFF_FFF0);
        do_fetch(0);
        do_resolve(1'b1, 1'b1, 1'b0, 16'h0004, 26'h0, 0, 0);
        chk("br_cross", PC, 32'h1000_0004);
        do_fetch(0);
        do_resolve(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 0, 0);
        chk("seq_hi", PC, 32'h1000_0008);
        do_fetch(4);
        do_resolve(1'b1, 1'b1, 1'b1, 16'h1234, 26'h0000010, 0, 0);
        chk("jmp_prio", PC, 32'h1000_0040);

        // Reset while a fetch is waiting for its ack.
        chkb("midwait_req", IMemReq, 1'b1);
        IMemAck = 1'b0;
        tick();
        tick();
        do_reset();
        chk("after_rst_addr", IMemAddr, 32'h0000_0040);

        // Reset in the middle of resolve.
        do_fetch(0);
        do_resolve(1'b0, 1'b0, 1'b1, 16'h0, 26'h0000100, 0, 0);
        do_fetch(1);
        do_reset();

        // Randomized traffic against the model.
        for (int n = 0; n < 40; n++) begin
            do_fetch(int'($urandom_range(0, 3)));
            do_resolve(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 3) == 0), 16'($urandom), 26'($urandom),
                       int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
